// File: rtl/delta_phase_mc.sv
// delta_phase_mc: multi-channel, time-interleaved phase differentiator.
// For every accepted sample it emits the phase increment against the sample
// LAG positions earlier on the same channel, one cycle later.
// Ports:
//   clk, reset (async active-low), clr (sync history clear)
//   in_valid / in_ch / theta       : input sample stream
//   out_valid / out_ch / delta_theta / out_first : registered result
//   err_ch                          : sticky out-of-range channel flag
module delta_phase_mc #(
  parameter int unsigned W    = 18,
  parameter int unsigned NCH  = 4,
  parameter int unsigned LAG  = 1,
  parameter int unsigned WRAP = 1,
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_ch,
  input  logic signed [W-1:0] theta,
  output logic                out_valid,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] delta_theta,
  output logic                out_first,
  output logic                err_ch
);

  localparam int unsigned PW = $clog2(LAG + 1);

  logic signed [W-1:0] hist_q [NCH][LAG];
  logic signed [W-1:0] hist_d [NCH][LAG];
  logic [PW-1:0]       prime_q [NCH];
  logic [PW-1:0]       prime_d [NCH];

  logic                out_valid_q, out_valid_d;
  logic [CW-1:0]       out_ch_q, out_ch_d;
  logic signed [W-1:0] delta_q, delta_d;
  logic                first_q, first_d;
  logic                err_q, err_d;

  logic                ch_ok;
  logic                acc;
  logic signed [W-1:0] sel_old;
  logic                sel_primed;
  logic [W:0]          diff;
  logic [W-1:0]        diff_f;

  // Next-state: history shift, prime counters and output payload
  always_comb begin
    hist_d      = hist_q;
    prime_d     = prime_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    delta_d     = delta_q;
    first_d     = first_q;
    err_d       = err_q;
    sel_old     = '0;
    sel_primed  = 1'b0;

    ch_ok = (32'(in_ch) < NCH);
    acc   = in_valid & ch_ok & ~clr;

    // Oldest tap and priming state of the addressed channel
    for (int unsigned c = 0; c < NCH; c++) begin
      if (32'(in_ch) == c) begin
        sel_old    = hist_q[c][LAG-1];
        sel_primed = (32'(prime_q[c]) >= LAG);
      end
    end

    // Extended difference; overflow shows as disagreement of the top two bits
    diff = {theta[W-1], theta} - {sel_old[W-1], sel_old};
    if (WRAP != 0) begin
      diff_f = diff[W-1:0];
    end else if (diff[W] != diff[W-1]) begin
      diff_f = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      diff_f = diff[W-1:0];
    end

    if (clr) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        prime_d[c] = '0;
        for (int unsigned l = 0; l < LAG; l++) begin
          hist_d[c][l] = '0;
        end
      end
      out_ch_d = '0;
      delta_d  = '0;
      first_d  = 1'b0;
      err_d    = 1'b0;
    end else if (in_valid && !ch_ok) begin
      err_d = 1'b1;
    end else if (acc) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      if (sel_primed) begin
        delta_d = diff_f;
        first_d = 1'b0;
      end else begin
        delta_d = '0;
        first_d = 1'b1;
      end
      for (int unsigned c = 0; c < NCH; c++) begin
        if (32'(in_ch) == c) begin
          if (!sel_primed) begin
            prime_d[c] = prime_q[c] + PW'(1);
          end
          for (int unsigned l = 1; l < LAG; l++) begin
            hist_d[c][l] = hist_q[c][l-1];
          end
          hist_d[c][0] = theta;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        prime_q[c] <= '0;
        for (int unsigned l = 0; l < LAG; l++) begin
          hist_q[c][l] <= '0;
        end
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      delta_q     <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      delta_q     <= delta_d;
      first_q     <= first_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign delta_theta = delta_q;
  assign out_first   = first_q;
  assign err_ch      = err_q;

endmodule

// File: tb/tb_delta_phase_mc.sv
// Testbench for delta_phase_mc: three parameterisations share one stimulus
// stream and are checked every cycle against a queue-based reference model.
//   u0: NCH=4 LAG=1 WRAP=1   u1: NCH=6 LAG=2 WRAP=1   u2: NCH=4 LAG=1 WRAP=0
module tb_delta_phase_mc;

  logic        clk;
  logic        reset;
  logic        s_clr;
  logic        s_valid;
  logic [2:0]  s_ch;
  logic signed [17:0] s_theta;

  logic        ov0, ov1, ov2;
  logic [1:0]  och0, och2;
  logic [2:0]  och1;
  logic signed [17:0] odt0, odt1, odt2;
  logic        ofi0, ofi1, ofi2;
  logic        oer0, oer1, oer2;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: per instance, per channel list of recent samples
  int p_nch [3] = '{4, 6, 4};
  int p_lag [3] = '{1, 2, 1};
  int p_wrap[3] = '{1, 1, 0};
  int mq [3][8][$];
  bit e_valid[3];
  int e_ch   [3];
  int e_delta[3];
  bit e_first[3];
  bit e_err  [3];

  delta_phase_mc #(.W(18), .NCH(4), .LAG(1), .WRAP(1)) u0 (
    .clk(clk), .reset(reset), .clr(s_clr), .in_valid(s_valid), .in_ch(s_ch[1:0]),
    .theta(s_theta), .out_valid(ov0), .out_ch(och0), .delta_theta(odt0),
    .out_first(ofi0), .err_ch(oer0));

  delta_phase_mc #(.W(18), .NCH(6), .LAG(2), .WRAP(1)) u1 (
    .clk(clk), .reset(reset), .clr(s_clr), .in_valid(s_valid), .in_ch(s_ch),
    .theta(s_theta), .out_valid(ov1), .out_ch(och1), .delta_theta(odt1),
    .out_first(ofi1), .err_ch(oer1));

  delta_phase_mc #(.W(18), .NCH(4), .LAG(1), .WRAP(0)) u2 (
    .clk(clk), .reset(reset), .clr(s_clr), .in_valid(s_valid), .in_ch(s_ch[1:0]),
    .theta(s_theta), .out_valid(ov2), .out_ch(och2), .delta_theta(odt2),
    .out_first(ofi2), .err_ch(oer2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 8; c++) mq[k][c].delete();
      e_valid[k] = 1'b0; e_ch[k] = 0; e_delta[k] = 0; e_first[k] = 1'b0; e_err[k] = 1'b0;
    end
  endfunction

  // Phase increment against the sample LAG positions back on the same channel
  function automatic void model_step(input bit c_clr, input bit v, input int ch, input int th);
    for (int k = 0; k < 3; k++) begin
      int lch;
      int d;
      lch = (k == 1) ? ch : (ch % 4);
      e_valid[k] = 1'b0;
      if (c_clr) begin
        for (int c = 0; c < 8; c++) mq[k][c].delete();
        e_ch[k] = 0; e_delta[k] = 0; e_first[k] = 1'b0; e_err[k] = 1'b0;
      end else if (v && lch >= p_nch[k]) begin
        e_err[k] = 1'b1;
      end else if (v) begin
        e_valid[k] = 1'b1;
        e_ch[k] = lch;
        if (mq[k][lch].size() < p_lag[k]) begin
          e_delta[k] = 0;
          e_first[k] = 1'b1;
        end else begin
          d = th - mq[k][lch][p_lag[k]-1];
          if (p_wrap[k] != 0) begin
            d = ((d % 262144) + 262144) % 262144;
            if (d >= 131072) d = d - 262144;
          end else begin
            if (d > 131071) d = 131071;
            if (d < -131072) d = -131072;
          end
          e_delta[k] = d;
          e_first[k] = 1'b0;
        end
        mq[k][lch].push_front(th);
        if (mq[k][lch].size() > p_lag[k]) void'(mq[k][lch].pop_back());
      end
    end
  endfunction

  task automatic check_all();
    chk("u0.valid", ov0, e_valid[0]); chk("u0.ch", och0, e_ch[0]);
    chk("u0.delta", odt0, e_delta[0]); chk("u0.first", ofi0, e_first[0]);
    chk("u0.err", oer0, e_err[0]);
    chk("u1.valid", ov1, e_valid[1]); chk("u1.ch", och1, e_ch[1]);
    chk("u1.delta", odt1, e_delta[1]); chk("u1.first", ofi1, e_first[1]);
    chk("u1.err", oer1, e_err[1]);
    chk("u2.valid", ov2, e_valid[2]); chk("u2.ch", och2, e_ch[2]);
    chk("u2.delta", odt2, e_delta[2]); chk("u2.first", ofi2, e_first[2]);
    chk("u2.err", oer2, e_err[2]);
  endtask

  // Apply one input cycle (called at negedge), check just after the edge
  task automatic cyc(input bit c, input bit v, input int ch, input int th);
    s_clr = c; s_valid = v; s_ch = 3'(ch); s_theta = 18'(th);
    model_step(c, v, ch, th);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; s_clr = 1'b0; s_valid = 1'b0; s_ch = '0; s_theta = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Priming
    cyc(0, 1, 0, 100);
    chk("prime.first", ofi0, 1); chk("prime.delta0", odt0, 0);
    cyc(0, 1, 0, 350);
    chk("prime.delta", odt0, 250); chk("prime.valid", ov0, 1);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("arst.valid", ov0, 0); chk("arst.delta", odt0, 0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 1, 0, 7);
    chk("arst.first", ofi0, 1); chk("arst.delta7", odt0, 0);

    // Wrap versus saturate
    cyc(0, 1, 1, 131000);
    cyc(0, 1, 1, -131000);
    chk("wrap.delta", odt0, 144); chk("sat.neg", odt2, -131072);
    cyc(0, 1, 1, 131000);
    chk("sat.pos", odt2, 131071); chk("wrap.back", odt0, -144);

    // Interleave on a cleared history
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 10);   chk("il.ch0", och0, 0);
    cyc(0, 1, 1, 1000); chk("il.ch1", och0, 1); chk("il.first1", ofi0, 1);
    cyc(0, 1, 0, 15);   chk("il.d0", odt0, 5);
    cyc(0, 1, 1, 900);  chk("il.d1", odt0, -100); chk("il.chlast", och0, 1);

    // LAG=2 on ch2
    cyc(0, 1, 2, 10);  chk("lag.f0", ofi1, 1);
    cyc(0, 1, 2, 20);  chk("lag.f1", ofi1, 1);
    cyc(0, 1, 2, 35);  chk("lag.d2", odt1, 25);
    cyc(0, 1, 2, 60);  chk("lag.d3", odt1, 40);

    // clr beats a simultaneous sample
    cyc(1, 1, 0, 500); chk("clr.valid", ov0, 0);
    cyc(0, 1, 0, 9);   chk("clr.first", ofi0, 1);

    // Out-of-range channel on the six-channel instance
    cyc(0, 1, 6, 1);   chk("bad.valid", ov1, 0); chk("bad.err", oer1, 1);
    cyc(0, 1, 7, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);   chk("bad.sticky", oer1, 1);
    cyc(1, 0, 0, 0);   chk("bad.clr", oer1, 0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      bit          rc;
      bit          rv;
      int          rch;
      logic signed [17:0] rt;
      rc  = ($urandom_range(0, 39) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rch = int'($urandom_range(0, 7));
      rt  = 18'($urandom());
      cyc(rc, rv, rch, int'(rt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
